glb_port_arbiter: RTL
=====================

Name: glb_port_arbiter

Overview:
- Shares the single-port global buffer (GLB) SRAM between the four NoC stream controllers: ifmap read, filter read, ipsum read, and opsum write.
- Performs at most one GLB access per cycle, using round-robin arbitration with an optional opsum-first priority.
- Routes read data back to the requester that issued the read, tagged with a per-requester valid.
- Sits between the NoC controller and the GLB macro.

Parameters:
- ADDR_WIDTH, 20, GLB word address width.
- DATA_WIDTH, 16, GLB word width (read and write).
- OPSUM_PRIORITY, 1, 1 = opsum write wins over all reads; 0 = pure round-robin over all four requesters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ifmap_req / filter_req / ipsum_req  in  1 each  read request
- ifmap_addr / filter_addr / ipsum_addr  in  ADDR_WIDTH each  read address
- ifmap_gnt / filter_gnt / ipsum_gnt  out  1 each  read accepted this cycle
- ifmap_rvalid / filter_rvalid / ipsum_rvalid  out  1 each  rdata valid for this requester
- opsum_req  in  1  write request
- opsum_addr  in  ADDR_WIDTH  write address
- opsum_wdata  in  DATA_WIDTH  write data
- opsum_gnt  out  1  write accepted this cycle
- rdata  out  DATA_WIDTH  read data, broadcast to all readers
- glb_en  out  1  GLB access enable
- glb_we  out  1  GLB write enable
- glb_addr  out  ADDR_WIDTH  GLB address
- glb_wdata  out  DATA_WIDTH  GLB write data
- glb_rdata  in  DATA_WIDTH  GLB read data, valid 1 cycle after a read access

Behaviour:
- Handshake: a requester holds req, addr and wdata stable until it sees gnt. A transfer occurs in any cycle with req && gnt. gnt is combinational from the reqs and the registered priority pointer.
- Exactly one gnt per cycle when any req is high; zero gnts when no req is high.
- glb_en = OR of all gnts. glb_we = opsum_gnt. glb_addr and glb_wdata are muxed from the granted requester. With no grant, glb_addr and glb_wdata are 0.
- Round-robin order is ifmap(0) → filter(1) → ipsum(2) → opsum(3).
- The 2-bit pointer holds the highest-priority index. After a grant to index i, the pointer becomes (i+1) mod 4. The pointer is unchanged in cycles with no grant.
- With OPSUM_PRIORITY=1:
  - opsum_req always wins, and the pointer is not updated on an opsum grant.
  - Reads rotate round-robin among indices 0–2 only; the pointer skips 3.
- Read return pipeline:
  - On a read grant, register a 2-bit requester id and a valid bit.
  - In the next cycle: rdata = glb_rdata, and the matching *_rvalid is asserted for exactly 1 cycle.
  - Back-to-back reads give back-to-back rvalids in grant order; there is no bubble.
  - A write cycle produces no rvalid.
- Fixed latencies: grant → GLB access in the same cycle; grant → rvalid is 1 cycle.
- Reset (asynchronous, also mid-operation):
  - Pointer → 0; return-pipeline valid → 0.
  - All gnt, rvalid, glb_en and glb_we forced to 0 while reset is high.
  - rdata, glb_addr and glb_wdata are 0 while reset is high.
  - A read granted in the cycle reset asserts never produces an rvalid.
- Requests dropped without a grant are legal: no state change.
- No backpressure on rvalid; requesters must sink read data unconditionally, as their gin FIFO slot is reserved before req is raised.

Optional Feature:
- Macro: GLB_PORT_ARBITER_PERF_CNT_EN.
- Defined: adds outputs grant_cnt[4] (32-bit each, incremented per grant to that requester) and conflict_cnt (32-bit, incremented on cycles with ≥2 reqs high).
  - All counters saturate at 32'hFFFF_FFFF.
  - All counters reset to 0 on reset.
  - Input clr_cnt (1-bit) synchronously zeroes all counters; clr_cnt wins over a same-cycle increment.
- Undefined: these ports and registers are absent; the arbitration function is identical.

Decomposition:
- Package glb_arb_pkg holds:
  - NUM_REQ = 4.
  - Enum req_id_e {REQ_IFMAP=0, REQ_FILTER=1, REQ_IPSUM=2, REQ_OPSUM=3}.
  - The 2-bit req_id_t typedef.
- Sub-module rr_arbiter4: a generic 4-way round-robin with inputs req[3:0], a mask and ptr, and outputs a one-hot gnt and next_ptr. The top level uses the mask for OPSUM_PRIORITY.

Test Plan:
1. Reset release, all req=0 for 5 cycles → glb_en=0, all gnt=0, all rvalid=0, pointer=0.
2. All four reqs held high, OPSUM_PRIORITY=0 → grant sequence ifmap, filter, ipsum, opsum, ifmap… over 8 cycles; glb_we=1 only on the opsum cycles.
3. OPSUM_PRIORITY=1, all reqs high, opsum deasserts after its 3rd grant → opsum granted cycles 0–2, then ifmap, filter, ipsum rotate.
4. Back-to-back reads: filter_addr=0x00010, then ifmap_addr=0x00020, with the GLB model returning 0xBEEF, 0x1234 → filter_rvalid with rdata=0xBEEF on cycle 1, ifmap_rvalid with rdata=0x1234 on cycle 2.
5. Reset asserted in the same cycle as an ipsum grant → ipsum_rvalid never asserts; pointer=0 after release.
6. With GLB_PORT_ARBITER_PERF_CNT_EN: 10 cycles of ifmap+filter contention → grant_cnt[0]=5, grant_cnt[1]=5, conflict_cnt=10; then clr_cnt for 1 cycle → all counters 0.

Source files
------------

// File: rtl/glb_arb_pkg.sv
// Shared types for the GLB port arbiter: requester ids and their count.
package glb_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    REQ_IFMAP  = 2'd0,
    REQ_FILTER = 2'd1,
    REQ_IPSUM  = 2'd2,
    REQ_OPSUM  = 2'd3
  } req_id_e;

  typedef logic [1:0] req_id_t;

endpackage

// File: rtl/glb_port_arbiter_rr.sv
// Generic 4-way round-robin picker. Searches from ptr upward (wrapping) over
// req & mask and returns a one-hot grant plus the pointer just past the winner.
// With nothing eligible, gnt is zero and next_ptr echoes ptr.
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] next_ptr
);

  logic [3:0] eligible;
  assign eligible = req & mask;

  // first eligible index at or after ptr wins
  always_comb begin
    logic       found;
    logic [1:0] idx;
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && eligible[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = idx + 2'd1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glb_port_arbiter.sv
// GLB port arbiter: one GLB access per cycle shared by ifmap/filter/ipsum
// readers and the opsum writer. Round-robin with optional opsum-first
// priority; read data returned one cycle after the grant with a per-reader
// valid. Optional perf counters under GLB_PORT_ARBITER_PERF_CNT_EN.
module glb_port_arbiter
  import glb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 16,
  parameter int OPSUM_PRIORITY = 1
) (
`ifdef GLB_PORT_ARBITER_PERF_CNT_EN
  input  logic                          clr_cnt,
  output logic [NUM_REQ-1:0][31:0]      grant_cnt,
  output logic [31:0]                   conflict_cnt,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifmap_req,
  input  logic [ADDR_WIDTH-1:0] ifmap_addr,
  output logic                  ifmap_gnt,
  output logic                  ifmap_rvalid,
  input  logic                  filter_req,
  input  logic [ADDR_WIDTH-1:0] filter_addr,
  output logic                  filter_gnt,
  output logic                  filter_rvalid,
  input  logic                  ipsum_req,
  input  logic [ADDR_WIDTH-1:0] ipsum_addr,
  output logic                  ipsum_gnt,
  output logic                  ipsum_rvalid,
  input  logic                  opsum_req,
  input  logic [ADDR_WIDTH-1:0] opsum_addr,
  input  logic [DATA_WIDTH-1:0] opsum_wdata,
  output logic                  opsum_gnt,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  glb_en,
  output logic                  glb_we,
  output logic [ADDR_WIDTH-1:0] glb_addr,
  output logic [DATA_WIDTH-1:0] glb_wdata,
  input  logic [DATA_WIDTH-1:0] glb_rdata
);

  localparam bit PRIO = (OPSUM_PRIORITY != 0);

  logic [NUM_REQ-1:0] req_vec, req_mask, arb_gnt, gnt;
  req_id_t            ptr_q, ptr_d, arb_next;
  logic               ret_vld;
  req_id_t            ret_id;

  assign req_vec = {opsum_req, ipsum_req, filter_req, ifmap_req};

  // opsum-first: a pending write masks every reader, otherwise the writer is masked out
  always_comb begin
    req_mask = 4'b1111;
    if (PRIO) req_mask = opsum_req ? 4'b1000 : 4'b0111;
  end

  rr_arbiter4 u_rr (
    .req      (req_vec),
    .mask     (req_mask),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .next_ptr (arb_next)
  );

  // grants are suppressed for as long as reset is held
  assign gnt = reset ? '0 : arb_gnt;

  assign ifmap_gnt  = gnt[REQ_IFMAP];
  assign filter_gnt = gnt[REQ_FILTER];
  assign ipsum_gnt  = gnt[REQ_IPSUM];
  assign opsum_gnt  = gnt[REQ_OPSUM];

  // pointer moves past the winner; in priority mode opsum grants leave it
  // alone and reader rotation wraps 2 -> 0
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt && !(PRIO && gnt[REQ_OPSUM])) begin
      ptr_d = (PRIO && arb_next == REQ_OPSUM) ? req_id_t'(REQ_IFMAP) : arb_next;
    end
  end

  // priority pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= REQ_IFMAP;
    else       ptr_q <= ptr_d;
  end

  // GLB request mux; idle cycles drive zeros
  always_comb begin
    glb_addr  = '0;
    glb_wdata = '0;
    if (gnt[REQ_IFMAP])  glb_addr = ifmap_addr;
    if (gnt[REQ_FILTER]) glb_addr = filter_addr;
    if (gnt[REQ_IPSUM])  glb_addr = ipsum_addr;
    if (gnt[REQ_OPSUM]) begin
      glb_addr  = opsum_addr;
      glb_wdata = opsum_wdata;
    end
  end

  assign glb_en = |gnt;
  assign glb_we = gnt[REQ_OPSUM];

  // read-return tag: who issued the read that the GLB answers next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ret_vld <= 1'b0;
      ret_id  <= REQ_IFMAP;
    end else begin
      ret_vld <= |gnt[REQ_IPSUM:REQ_IFMAP];
      ret_id  <= gnt[REQ_FILTER] ? req_id_t'(REQ_FILTER) :
                 gnt[REQ_IPSUM]  ? req_id_t'(REQ_IPSUM)  : req_id_t'(REQ_IFMAP);
    end
  end

  assign ifmap_rvalid  = ret_vld && (ret_id == REQ_IFMAP);
  assign filter_rvalid = ret_vld && (ret_id == REQ_FILTER);
  assign ipsum_rvalid  = ret_vld && (ret_id == REQ_IPSUM);
  assign rdata         = ret_vld ? glb_rdata : '0;

`ifdef GLB_PORT_ARBITER_PERF_CNT_EN
  logic conflict;
  assign conflict = ($countones(req_vec) >= 2);

  // saturating grant/conflict counters; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else if (clr_cnt) begin
      grant_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && grant_cnt[i] != 32'hFFFF_FFFF) grant_cnt[i] <= grant_cnt[i] + 32'd1;
      end
      if (conflict && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end
`endif

endmodule
